// File: rtl/frame_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter.
// Holds the serializer state encoding, status bit positions and a constant log2.
package frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam int STAT_BUF_FULL  = 0;
    localparam int STAT_BUF_EMPTY = 1;
    localparam int STAT_DATA_OVF  = 2;
    localparam int STAT_FRAME_OVF = 3;
    localparam int STAT_BUSY      = 4;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_len_fifo.sv
// Synchronous FIFO of committed frame lengths.
// Pushes when full and pops when empty are ignored.
module frame_len_fifo
    import frame_tx_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [W-1:0]          data_i,
    output logic [W-1:0]          data_o,
    output logic [clog2(DEPTH):0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          do_push, do_pop;

    assign count_o = wp_q - rp_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (wp_q == rp_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rp_q[AW-1:0]];
    assign wp_d    = wp_q + CW'(do_push);
    assign rp_d    = rp_q + CW'(do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/frame_tx_engine.sv
// Framed serial transmitter: buffered words with checkpoint/rollback, whole-frame
// commit, and a start/data/stop serializer with idle gaps between frames.
module frame_tx_engine
    import frame_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int MAX_FRAMES = 16,
    parameter int BIT_DIV    = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_data_we,
    input  logic                       i_push_write_index,
    input  logic                       i_pop_write_index,
    input  logic                       i_push_frame,
    input  logic                       i_tx_en,
    input  logic                       i_clr_status,
    output logic [clog2(DEPTH):0]      o_data_size,
    output logic [clog2(MAX_FRAMES):0] o_frames_count,
    output logic [7:0]                 o_status,
    output logic                       o_tx,
    output logic                       o_sync
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DIV_W  = clog2(BIT_DIV) + 1;
    localparam int BC_W   = clog2(DATA_W + GAP_BITS) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, fs_q, fs_d, chk_q, chk_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_w, chk_w, len, occ, size_q, size_d;
    logic              full, wr_ok, commit, frame_drop;
    logic              data_ovf_q, data_ovf_d, frame_ovf_q, frame_ovf_d;
    logic              q_full, q_empty, q_pop;
    logic [PTR_W-1:0]  q_len;

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [PTR_W-1:0]  left_q, left_d;
    logic              first_q, first_d, ld_word, bit_end;

    // Same-cycle order: write, checkpoint, rollback, commit.
    always_comb begin
        occ        = wr_ptr_q - rd_ptr_q;
        full       = (occ == PTR_W'(DEPTH));
        wr_ok      = i_data_we && !full;
        wr_w       = wr_ptr_q + PTR_W'(wr_ok);
        chk_w      = i_push_write_index ? wr_w : chk_q;
        wr_ptr_d   = i_pop_write_index ? chk_w : wr_w;
        len        = wr_ptr_d - fs_q;
        commit     = i_push_frame && (len != '0) && !q_full;
        frame_drop = i_push_frame && (len != '0) && q_full;
        fs_d       = commit ? wr_ptr_d : fs_q;
        chk_d      = commit ? wr_ptr_d : chk_w;
        data_ovf_d  = (i_data_we && full) ? 1'b1 : (i_clr_status ? 1'b0 : data_ovf_q);
        frame_ovf_d = frame_drop ? 1'b1 : (i_clr_status ? 1'b0 : frame_ovf_q);
    end

    assign size_d   = size_q + (commit ? len : '0) - PTR_W'(ld_word);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(ld_word);
    assign bit_end  = (div_q == DIV_W'(BIT_DIV - 1));

    frame_len_fifo #(.W(PTR_W), .DEPTH(MAX_FRAMES)) u_len_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (commit),
        .pop_i   (q_pop),
        .data_i  (len),
        .data_o  (q_len),
        .count_o (o_frames_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // A commit in this very cycle is enough to leave IDLE, so the start bit
    // lands two clocks after the push_frame strobe.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        left_d  = left_q;
        first_d = first_q;
        q_pop   = 1'b0;
        ld_word = 1'b0;
        if (state_q != ST_IDLE && state_q != ST_LOAD) div_d = bit_end ? '0 : div_q + DIV_W'(1);
        case (state_q)
            ST_IDLE: if (i_tx_en && (!q_empty || commit)) state_d = ST_LOAD;
            ST_LOAD: begin
                q_pop   = 1'b1;
                ld_word = 1'b1;
                left_d  = q_len - PTR_W'(1);
                first_d = 1'b1;
                div_d   = '0;
                state_d = ST_START;
            end
            ST_START: if (bit_end) begin
                first_d = 1'b0;
                bit_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                sh_d = sh_q >> 1;
                if (bit_q == BC_W'(DATA_W - 1)) state_d = ST_STOP;
                else bit_d = bit_q + BC_W'(1);
            end
            ST_STOP: if (bit_end) begin
                if (left_q != '0) begin
                    ld_word = 1'b1;
                    left_d  = left_q - PTR_W'(1);
                    state_d = ST_START;
                end else begin
                    bit_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: if (bit_end) begin
                if (bit_q == BC_W'(GAP_BITS - 1)) state_d = ST_IDLE;
                else bit_d = bit_q + BC_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (ld_word) sh_d = mem[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            fs_q        <= '0;
            chk_q       <= '0;
            rd_ptr_q    <= '0;
            size_q      <= '0;
            data_ovf_q  <= 1'b0;
            frame_ovf_q <= 1'b0;
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            left_q      <= '0;
            first_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fs_q        <= fs_d;
            chk_q       <= chk_d;
            rd_ptr_q    <= rd_ptr_d;
            size_q      <= size_d;
            data_ovf_q  <= data_ovf_d;
            frame_ovf_q <= frame_ovf_d;
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            left_q      <= left_d;
            first_q     <= first_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr_q[ADDR_W-1:0]] <= i_data;
    end

    // Line is decoded from registered state so reset forces it high at once.
    always_comb begin
        o_status                 = 8'h00;
        o_status[STAT_BUF_FULL]  = full;
        o_status[STAT_BUF_EMPTY] = (occ == '0);
        o_status[STAT_DATA_OVF]  = data_ovf_q;
        o_status[STAT_FRAME_OVF] = frame_ovf_q;
        o_status[STAT_BUSY]      = (state_q != ST_IDLE);
    end

    assign o_tx        = (state_q == ST_START) ? 1'b0 : ((state_q == ST_DATA) ? sh_q[0] : 1'b1);
    assign o_sync      = (state_q == ST_START) && first_q;
    assign o_data_size = size_q;

endmodule
